// File: rtl/axi_tdd_frame_counter_if.sv
// Bundles the register-map inputs and the status outputs of the TDD frame counter.
// The core connects through the slave modport; the register map or a bench uses master.
interface axi_tdd_frame_counter_if #(
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32,
  parameter int SYNC_COUNT_WIDTH  = 64
);
  logic                         tdd_enable;
  logic                         tdd_sync_rst;
  logic                         tdd_sync_int_en;
  logic                         tdd_sync_ext_en;
  logic                         tdd_sync_soft;
  logic                         sync_in;
  logic [SYNC_COUNT_WIDTH-1:0]  tdd_sync_period;
  logic [REGISTER_WIDTH-1:0]    tdd_startup_delay;
  logic [REGISTER_WIDTH-1:0]    tdd_frame_length;
  logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count;

  logic [1:0]                   tdd_cstate;
  logic [REGISTER_WIDTH-1:0]    tdd_counter;
  logic                         tdd_endof_frame;
  logic                         tdd_sync_out;

  modport master (
    output tdd_enable, tdd_sync_rst, tdd_sync_int_en, tdd_sync_ext_en, tdd_sync_soft,
           sync_in, tdd_sync_period, tdd_startup_delay, tdd_frame_length, tdd_burst_count,
    input  tdd_cstate, tdd_counter, tdd_endof_frame, tdd_sync_out
  );

  modport slave (
    input  tdd_enable, tdd_sync_rst, tdd_sync_int_en, tdd_sync_ext_en, tdd_sync_soft,
           sync_in, tdd_sync_period, tdd_startup_delay, tdd_frame_length, tdd_burst_count,
    output tdd_cstate, tdd_counter, tdd_endof_frame, tdd_sync_out
  );
endinterface

// File: rtl/axi_tdd_frame_counter.sv
// TDD timing core: sync trigger selection, internal periodic sync generator and the
// IDLE/ARMED/WAITING/RUNNING frame sequencer with registered state, counter and strobes.
module axi_tdd_frame_counter #(
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32,
  parameter int SYNC_COUNT_WIDTH  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_tdd_frame_counter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_WAITING = 2'b10,
    ST_RUNNING = 2'b11
  } state_t;

  state_t                       state_q, state_d;
  logic [REGISTER_WIDTH-1:0]    counter_q, counter_d;
  logic [BURST_COUNT_WIDTH-1:0] tally_q, tally_d;
  logic [SYNC_COUNT_WIDTH-1:0]  sync_cnt_q, sync_cnt_d;
  logic                         sync_in_d_q;
  logic                         eof_q, eof_d;
  logic                         sync_out_q, sync_out_d;

  logic                         sync_run;
  logic                         int_pulse;
  logic                         trigger;
  logic                         accept;
  logic [REGISTER_WIDTH-1:0]    frame_last;
  logic [REGISTER_WIDTH-1:0]    delay_last;
  logic [BURST_COUNT_WIDTH-1:0] burst_last;

  // Internal sync generator: free-running modulo-period counter, held at 0 when unused.
  always_comb begin
    sync_run   = bus.tdd_enable & bus.tdd_sync_int_en & (bus.tdd_sync_period != '0);
    int_pulse  = sync_run & (sync_cnt_q == (bus.tdd_sync_period - SYNC_COUNT_WIDTH'(1)));
    sync_cnt_d = (!sync_run || int_pulse) ? '0 : sync_cnt_q + SYNC_COUNT_WIDTH'(1);
  end

  always_comb begin
    trigger = (bus.tdd_sync_ext_en & bus.sync_in & ~sync_in_d_q)
            | (bus.tdd_sync_int_en & int_pulse)
            | bus.tdd_sync_soft;
  end

  always_comb begin
    frame_last = (bus.tdd_frame_length == '0) ? '0
               : bus.tdd_frame_length - REGISTER_WIDTH'(1);
    delay_last = bus.tdd_startup_delay - REGISTER_WIDTH'(1);
    burst_last = bus.tdd_burst_count - BURST_COUNT_WIDTH'(1);
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    tally_d    = tally_q;
    sync_out_d = 1'b0;
    accept     = 1'b0;

    if (!bus.tdd_enable) begin
      state_d   = ST_IDLE;
      counter_d = '0;
      tally_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          counter_d = '0;
          state_d   = ST_ARMED;
        end
        ST_ARMED: begin
          counter_d = '0;
          accept    = trigger;
        end
        ST_WAITING: begin
          counter_d = counter_q + REGISTER_WIDTH'(1);
          if (counter_q == delay_last) begin
            state_d   = ST_RUNNING;
            counter_d = '0;
          end
          accept = trigger & bus.tdd_sync_rst;
        end
        ST_RUNNING: begin
          counter_d = counter_q + REGISTER_WIDTH'(1);
          if (counter_q == frame_last) begin
            counter_d = '0;
            if ((bus.tdd_burst_count != '0) && (tally_q == burst_last)) begin
              state_d = ST_ARMED;
              tally_d = '0;
            end else begin
              tally_d = tally_q + BURST_COUNT_WIDTH'(1);
            end
          end
          accept = trigger & bus.tdd_sync_rst;
        end
        default: begin
          state_d   = ST_IDLE;
          counter_d = '0;
          tally_d   = '0;
        end
      endcase

      // An accepted sync (first start or restart) overrides frame-end bookkeeping.
      if (accept) begin
        state_d    = (bus.tdd_startup_delay != '0) ? ST_WAITING : ST_RUNNING;
        counter_d  = '0;
        tally_d    = '0;
        sync_out_d = 1'b1;
      end
    end
  end

  // Look ahead one cycle so the registered strobe lines up with the last counter value.
  always_comb begin
    eof_d = (state_d == ST_RUNNING) && (counter_d == frame_last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      counter_q   <= '0;
      tally_q     <= '0;
      sync_cnt_q  <= '0;
      sync_in_d_q <= 1'b0;
      eof_q       <= 1'b0;
      sync_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      tally_q     <= tally_d;
      sync_cnt_q  <= sync_cnt_d;
      sync_in_d_q <= bus.sync_in;
      eof_q       <= eof_d;
      sync_out_q  <= sync_out_d;
    end
  end

  assign bus.tdd_cstate      = state_q;
  assign bus.tdd_counter     = counter_q;
  assign bus.tdd_endof_frame = eof_q;
  assign bus.tdd_sync_out    = sync_out_q;

endmodule

// File: tb/tb_axi_tdd_frame_counter.sv
// Directed self-checking bench for axi_tdd_frame_counter; each task covers one scenario.
module tb_axi_tdd_frame_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  axi_tdd_frame_counter_if #(.REGISTER_WIDTH(32), .BURST_COUNT_WIDTH(32), .SYNC_COUNT_WIDTH(64)) bus ();

  axi_tdd_frame_counter #(
    .REGISTER_WIDTH(32), .BURST_COUNT_WIDTH(32), .SYNC_COUNT_WIDTH(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    if ({bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out} !== 36'd0) begin
      errors++;
      $display("FAIL reset_state: got st=%0d cnt=%0d eof=%b so=%b want all 0",
               bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out);
    end
    checks++;
    rst = 1'b0;
    tick();
    if (bus.tdd_cstate !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle_hold: got st=%0d want 0", bus.tdd_cstate);
    end
    checks++;
    $display("test_reset done");
  endtask

  task automatic test_basic;
    logic [31:0] exp_cnt;
    bus.tdd_startup_delay = 32'd3;
    bus.tdd_frame_length  = 32'd5;
    bus.tdd_burst_count   = 32'd2;
    bus.tdd_enable        = 1'b1;
    bus.tdd_sync_soft     = 1'b1;
    tick();
    if ({bus.tdd_cstate, bus.tdd_sync_out} !== 3'b010) begin
      errors++;
      $display("FAIL basic_enable_trig_ignored: got st=%0d so=%b want st=1 so=0",
               bus.tdd_cstate, bus.tdd_sync_out);
    end
    checks++;
    tick();
    bus.tdd_sync_soft = 1'b0;
    if ({bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out} !== {2'b10, 32'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_trigger: got st=%0d cnt=%0d eof=%b so=%b want st=2 cnt=0 eof=0 so=1",
               bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out);
    end
    checks++;
    for (int i = 1; i < 3; i++) begin
      tick();
      exp_cnt = 32'(i);
      if ({bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out} !== {2'b10, exp_cnt, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL basic_wait: got st=%0d cnt=%0d eof=%b want st=2 cnt=%0d eof=0",
                 bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, exp_cnt);
      end
      checks++;
    end
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 5; c++) begin
        tick();
        exp_cnt = 32'(c);
        if ({bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out} !== {2'b11, exp_cnt, (c == 4), 1'b0}) begin
          errors++;
          $display("FAIL basic_run f%0d: got st=%0d cnt=%0d eof=%b want st=3 cnt=%0d eof=%b",
                   f, bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, exp_cnt, (c == 4));
        end
        checks++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      if ({bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame} !== {2'b01, 32'd0, 1'b0}) begin
        errors++;
        $display("FAIL basic_burst_done: got st=%0d cnt=%0d eof=%b want st=1 cnt=0 eof=0",
                 bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame);
      end
      checks++;
    end
    $display("test_basic done");
  endtask

  task automatic test_zero_cases;
    logic [31:0] exp_cnt;
    bus.tdd_enable = 1'b0;
    tick();
    bus.tdd_startup_delay = 32'd0;
    bus.tdd_burst_count   = 32'd0;
    bus.tdd_frame_length  = 32'd4;
    bus.tdd_enable        = 1'b1;
    tick();
    bus.tdd_sync_soft = 1'b1;
    tick();
    bus.tdd_sync_soft = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) tick();
      exp_cnt = 32'(i % 4);
      if ({bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out} !== {2'b11, exp_cnt, (i % 4 == 3), (i == 0)}) begin
        errors++;
        $display("FAIL zero_delay_inf i%0d: got st=%0d cnt=%0d eof=%b so=%b want st=3 cnt=%0d eof=%b so=%b",
                 i, bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out,
                 exp_cnt, (i % 4 == 3), (i == 0));
      end
      checks++;
    end
    bus.tdd_enable = 1'b0;
    tick();
    bus.tdd_frame_length = 32'd0;
    bus.tdd_enable       = 1'b1;
    tick();
    bus.tdd_sync_soft = 1'b1;
    tick();
    bus.tdd_sync_soft = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      if ({bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out} !== {2'b11, 32'd0, 1'b1, (i == 0)}) begin
        errors++;
        $display("FAIL zero_frame i%0d: got st=%0d cnt=%0d eof=%b so=%b want st=3 cnt=0 eof=1 so=%b",
                 i, bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out, (i == 0));
      end
      checks++;
    end
    $display("test_zero_cases done");
  endtask

  task automatic test_ext_edge;
    int pulses;
    bus.tdd_enable = 1'b0;
    tick();
    bus.tdd_frame_length = 32'd100;
    bus.tdd_sync_ext_en  = 1'b1;
    bus.tdd_sync_rst     = 1'b1;
    bus.tdd_enable       = 1'b1;
    tick();
    pulses = 0;
    bus.sync_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) bus.sync_in = 1'b0;
      tick();
      if (bus.tdd_sync_out === 1'b1) pulses++;
    end
    if (pulses !== 1) begin
      errors++;
      $display("FAIL ext_one_pulse: got pulses=%0d want 1", pulses);
    end
    checks++;
    if ({bus.tdd_cstate, bus.tdd_counter} !== {2'b11, 32'd11}) begin
      errors++;
      $display("FAIL ext_no_retrigger: got st=%0d cnt=%0d want st=3 cnt=11", bus.tdd_cstate, bus.tdd_counter);
    end
    checks++;
    bus.tdd_sync_ext_en = 1'b0;
    bus.tdd_enable      = 1'b0;
    tick();
    bus.tdd_enable = 1'b1;
    tick();
    pulses = 0;
    bus.sync_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) bus.sync_in = 1'b0;
      tick();
      if (bus.tdd_sync_out === 1'b1) pulses++;
    end
    if ({pulses[7:0], bus.tdd_cstate} !== {8'd0, 2'b01}) begin
      errors++;
      $display("FAIL ext_disabled: got pulses=%0d st=%0d want pulses=0 st=1", pulses, bus.tdd_cstate);
    end
    checks++;
    $display("test_ext_edge done");
  endtask

  task automatic test_int_sync;
    logic [31:0] exp_cnt;
    bus.tdd_enable = 1'b0;
    tick();
    bus.tdd_sync_period = 64'd8;
    bus.tdd_sync_int_en = 1'b1;
    bus.tdd_sync_rst    = 1'b1;
    bus.tdd_frame_length = 32'd20;
    tick();
    bus.tdd_enable = 1'b1;
    tick();
    for (int j = 0; j < 6; j++) begin
      tick();
      if ({bus.tdd_cstate, bus.tdd_sync_out} !== 3'b010) begin
        errors++;
        $display("FAIL int_wait j%0d: got st=%0d so=%b want st=1 so=0", j, bus.tdd_cstate, bus.tdd_sync_out);
      end
      checks++;
    end
    tick();
    if ({bus.tdd_cstate, bus.tdd_counter, bus.tdd_sync_out} !== {2'b11, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL int_first_pulse: got st=%0d cnt=%0d so=%b want st=3 cnt=0 so=1",
               bus.tdd_cstate, bus.tdd_counter, bus.tdd_sync_out);
    end
    checks++;
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp_cnt = 32'(k % 8);
      if ({bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out} !== {2'b11, exp_cnt, 1'b0, (k % 8 == 0)}) begin
        errors++;
        $display("FAIL int_restart k%0d: got st=%0d cnt=%0d eof=%b so=%b want st=3 cnt=%0d eof=0 so=%b",
                 k, bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out, exp_cnt, (k % 8 == 0));
      end
      checks++;
    end
    bus.tdd_sync_rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_cnt = 32'(k % 20);
      if ({bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out} !== {2'b11, exp_cnt, (k % 20 == 19), 1'b0}) begin
        errors++;
        $display("FAIL int_no_restart k%0d: got st=%0d cnt=%0d eof=%b so=%b want st=3 cnt=%0d eof=%b so=0",
                 k, bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out, exp_cnt, (k % 20 == 19));
      end
      checks++;
    end
    bus.tdd_sync_int_en = 1'b0;
    bus.tdd_sync_period = 64'd0;
    $display("test_int_sync done");
  endtask

  task automatic test_disable;
    bus.tdd_enable = 1'b0;
    tick();
    bus.tdd_frame_length  = 32'd9;
    bus.tdd_startup_delay = 32'd0;
    bus.tdd_burst_count   = 32'd0;
    bus.tdd_enable        = 1'b1;
    tick();
    bus.tdd_sync_soft = 1'b1;
    tick();
    bus.tdd_sync_soft = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    if ({bus.tdd_cstate, bus.tdd_counter} !== {2'b11, 32'd7}) begin
      errors++;
      $display("FAIL disable_pre: got st=%0d cnt=%0d want st=3 cnt=7", bus.tdd_cstate, bus.tdd_counter);
    end
    checks++;
    bus.tdd_enable = 1'b0;
    tick();
    if ({bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out} !== {2'b00, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL disable_idle: got st=%0d cnt=%0d eof=%b so=%b want st=0 cnt=0 eof=0 so=0",
               bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out);
    end
    checks++;
    bus.tdd_enable = 1'b1;
    tick();
    if ({bus.tdd_cstate, bus.tdd_counter} !== {2'b01, 32'd0}) begin
      errors++;
      $display("FAIL disable_rearm: got st=%0d cnt=%0d want st=1 cnt=0", bus.tdd_cstate, bus.tdd_counter);
    end
    checks++;
    $display("test_disable done");
  endtask

  task automatic test_restart_at_eof;
    bus.tdd_enable = 1'b0;
    tick();
    bus.tdd_startup_delay = 32'd2;
    bus.tdd_frame_length  = 32'd5;
    bus.tdd_burst_count   = 32'd0;
    bus.tdd_sync_rst      = 1'b1;
    bus.tdd_enable        = 1'b1;
    tick();
    bus.tdd_sync_soft = 1'b1;
    tick();
    bus.tdd_sync_soft = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    if ({bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame} !== {2'b11, 32'd4, 1'b1}) begin
      errors++;
      $display("FAIL restart_eof_pre: got st=%0d cnt=%0d eof=%b want st=3 cnt=4 eof=1",
               bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame);
    end
    checks++;
    bus.tdd_sync_soft = 1'b1;
    tick();
    bus.tdd_sync_soft = 1'b0;
    if ({bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out} !== {2'b10, 32'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL restart_eof_wins: got st=%0d cnt=%0d eof=%b so=%b want st=2 cnt=0 eof=0 so=1",
               bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out);
    end
    checks++;
    bus.tdd_sync_rst = 1'b0;
    $display("test_restart_at_eof done");
  endtask

  task automatic test_rst_waiting;
    bus.tdd_enable = 1'b0;
    tick();
    bus.tdd_startup_delay = 32'd10;
    bus.tdd_frame_length  = 32'd5;
    bus.tdd_burst_count   = 32'd1;
    bus.tdd_enable        = 1'b1;
    tick();
    bus.tdd_sync_soft = 1'b1;
    tick();
    bus.tdd_sync_soft = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    if ({bus.tdd_cstate, bus.tdd_counter} !== {2'b10, 32'd3}) begin
      errors++;
      $display("FAIL rst_pre: got st=%0d cnt=%0d want st=2 cnt=3", bus.tdd_cstate, bus.tdd_counter);
    end
    checks++;
    #2 rst = 1'b1;
    #1;
    if ({bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out} !== 36'd0) begin
      errors++;
      $display("FAIL rst_async: got st=%0d cnt=%0d eof=%b so=%b want all 0",
               bus.tdd_cstate, bus.tdd_counter, bus.tdd_endof_frame, bus.tdd_sync_out);
    end
    checks++;
    tick();
    rst = 1'b0;
    if (bus.tdd_cstate !== 2'b00) begin
      errors++;
      $display("FAIL rst_held_idle: got st=%0d want 0", bus.tdd_cstate);
    end
    checks++;
    tick();
    if (bus.tdd_cstate !== 2'b01) begin
      errors++;
      $display("FAIL rst_rearm: got st=%0d want 1", bus.tdd_cstate);
    end
    checks++;
    bus.tdd_sync_soft = 1'b1;
    tick();
    bus.tdd_sync_soft = 1'b0;
    if ({bus.tdd_cstate, bus.tdd_counter, bus.tdd_sync_out} !== {2'b10, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL rst_restart: got st=%0d cnt=%0d so=%b want st=2 cnt=0 so=1",
               bus.tdd_cstate, bus.tdd_counter, bus.tdd_sync_out);
    end
    checks++;
    $display("test_rst_waiting done");
  endtask

  initial begin
    bus.tdd_enable        = 1'b0;
    bus.tdd_sync_rst      = 1'b0;
    bus.tdd_sync_int_en   = 1'b0;
    bus.tdd_sync_ext_en   = 1'b0;
    bus.tdd_sync_soft     = 1'b0;
    bus.sync_in           = 1'b0;
    bus.tdd_sync_period   = 64'd0;
    bus.tdd_startup_delay = 32'd0;
    bus.tdd_frame_length  = 32'd0;
    bus.tdd_burst_count   = 32'd0;

    test_reset();
    test_basic();
    test_zero_cases();
    test_ext_edge();
    test_int_sync();
    test_disable();
    test_restart_at_eof();
    test_rst_waiting();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
